// File: rtl/rsa_sequencer.sv
// rtl/rsa_sequencer.sv - control sequencer for a Montgomery-multiplier based modular exponentiator
module rsa_sequencer #(
    parameter int WIDTH      = 8,
    parameter int EXP_WIDTH  = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic                                 clk,
    input  logic                                 rstb,
    input  logic                                 ena,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [EXP_WIDTH-1:0]                 E,
    input  logic [$clog2(EXP_WIDTH+1)-1:0]       exp_len,
    output logic                                 clear_mmm,
    output logic                                 ld_a,
    output logic                                 ld_r,
    output logic                                 lock1,
    output logic                                 lock2,
    output logic                                 sel2,
    output logic [1:0]                           sel1,
    output logic                                 busy,
    output logic                                 eoc,
    output logic [$clog2(EXP_WIDTH+1)-1:0]       rounds_done
);

    localparam int CW = $clog2(EXP_WIDTH + 1);
    localparam int SW = $clog2(WIDTH);
    localparam logic [CW-1:0] RMAX = CW'(EXP_WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE, PRE_MAP, MAP, POST_MAP, PRE_MMM, MMM, POST_MMM,
        PRE_REMAP, REMAP, POST_REMAP, EOC
    } state_t;

    state_t               state, state_nxt;
    logic [SW-1:0]        step;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [CW-1:0]        r_q;
    logic [CW-1:0]        rd_inc;
    logic                 early_done;

    assign rd_inc     = rounds_done + CW'(1);
    assign early_done = (EARLY_EXIT != 0) && ((exp_q >> 1) == '0);

    always_ff @(posedge clk) begin
        if (rstb) begin
            state       <= IDLE;
            exp_q       <= '0;
            step        <= '0;
            rounds_done <= '0;
            r_q         <= RMAX;
        end else if (abort) begin
            // rounds_done is kept so software can see how far the aborted run got
            state <= IDLE;
            exp_q <= '0;
            step  <= '0;
        end else if (ena) begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q       <= E;
                        r_q         <= (exp_len == '0 || exp_len > RMAX) ? RMAX : exp_len;
                        step        <= '0;
                        rounds_done <= '0;
                    end
                end
                MAP, MMM, REMAP: step <= (step == LAST) ? '0 : step + SW'(1);
                POST_MAP, POST_REMAP: step <= '0;
                POST_MMM: begin
                    step        <= '0;
                    exp_q       <= exp_q >> 1;
                    rounds_done <= rd_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = start ? PRE_MAP : IDLE;
            PRE_MAP:    state_nxt = MAP;
            MAP:        state_nxt = (step == LAST) ? POST_MAP : MAP;
            POST_MAP:   state_nxt = PRE_MMM;
            PRE_MMM:    state_nxt = MMM;
            MMM:        state_nxt = (step == LAST) ? POST_MMM : MMM;
            POST_MMM:   state_nxt = (rd_inc == r_q || early_done) ? PRE_REMAP : PRE_MMM;
            PRE_REMAP:  state_nxt = REMAP;
            REMAP:      state_nxt = (step == LAST) ? POST_REMAP : REMAP;
            POST_REMAP: state_nxt = EOC;
            EOC:        state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clear_mmm = 1'b0;
        ld_a      = 1'b0;
        ld_r      = 1'b0;
        lock1     = 1'b0;
        lock2     = 1'b0;
        sel1      = 2'b00;
        sel2      = 1'b0;
        busy      = 1'b0;
        eoc       = 1'b0;
        case (state)
            PRE_MAP, MAP, POST_MAP: begin
                clear_mmm = 1'b1;
                lock1     = 1'b1;
                lock2     = 1'b1;
                busy      = 1'b1;
                ld_a      = (state == PRE_MAP);
                ld_r      = (state == POST_MAP);
            end
            PRE_MMM, MMM, POST_MMM: begin
                clear_mmm = 1'b1;
                lock1     = exp_q[0];
                lock2     = 1'b1;
                sel1      = 2'b01;
                sel2      = 1'b1;
                busy      = 1'b1;
                ld_a      = (state == PRE_MMM);
                ld_r      = (state == POST_MMM);
            end
            PRE_REMAP, REMAP, POST_REMAP, EOC: begin
                clear_mmm = 1'b1;
                lock1     = 1'b1;
                sel1      = 2'b10;
                sel2      = 1'b1;
                busy      = 1'b1;
                ld_a      = (state == PRE_REMAP);
                ld_r      = (state == POST_REMAP) || (state == EOC);
                eoc       = (state == EOC);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rsa_sequencer.sv
// tb/tb_rsa_sequencer.sv - bench for rsa_sequencer with both early-exit variants side by side
module tb_rsa_sequencer;
    localparam int W  = 8;
    localparam int EW = 8;
    localparam int CW = $clog2(EW + 1);
    localparam int PH = W + 2;

    logic clk = 1'b0;
    logic rstb, ena, start, abort;
    logic [EW-1:0] e;
    logic [CW-1:0] exp_len;
    logic [1:0] clear_mmm, ld_a, ld_r, lock1, lock2, sel2, busy, eoc;
    logic [1:0] sel1_0, sel1_1;
    logic [CW-1:0] rd0, rd1;

    always #5 clk = ~clk;

    rsa_sequencer #(.WIDTH(W), .EXP_WIDTH(EW), .EARLY_EXIT(0)) u0 (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start), .abort(abort), .E(e), .exp_len(exp_len),
        .clear_mmm(clear_mmm[0]), .ld_a(ld_a[0]), .ld_r(ld_r[0]), .lock1(lock1[0]), .lock2(lock2[0]),
        .sel2(sel2[0]), .sel1(sel1_0), .busy(busy[0]), .eoc(eoc[0]), .rounds_done(rd0));

    rsa_sequencer #(.WIDTH(W), .EXP_WIDTH(EW), .EARLY_EXIT(1)) u1 (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start), .abort(abort), .E(e), .exp_len(exp_len),
        .clear_mmm(clear_mmm[1]), .ld_a(ld_a[1]), .ld_r(ld_r[1]), .lock1(lock1[1]), .lock2(lock2[1]),
        .sel2(sel2[1]), .sel1(sel1_1), .busy(busy[1]), .eoc(eoc[1]), .rounds_done(rd1));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model: an operation is a position p counted in enabled cycles since start
    bit          act[2];
    int          p[2], rx[2], mrd[2], eocp[2];
    logic [EW-1:0] me[2];
    int          cyc[2], eoc_at[2], nlk[2];
    logic [EW-1:0] lk[2];

    function automatic int calc_rx(input logic [EW-1:0] ev, input int len, input bit early);
        int r;
        int hi;
        r = (len == 0 || len > EW) ? EW : len;
        if (early) begin
            hi = 1;
            for (int b = 0; b < EW; b++) if (ev[b]) hi = b + 1;
            if (hi < r) r = hi;
        end
        return r;
    endfunction

    function automatic logic [9:0] model_out(input int i);
        int ph, o;
        logic la, lr;
        if (!act[i]) return 10'd0;
        if (p[i] == eocp[i]) return {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1};
        ph = (p[i] - 1) / PH;
        o  = (p[i] - 1) % PH;
        la = (o == 0);
        lr = (o == PH - 1);
        if (ph == 0) return {1'b1, la, lr, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
        if (ph <= rx[i]) return {1'b1, la, lr, me[i][ph-1], 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
        return {1'b1, la, lr, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0};
    endfunction

    function automatic logic [9:0] dut_out(input int i);
        if (i == 0)
            return {clear_mmm[0], ld_a[0], ld_r[0], lock1[0], lock2[0], sel1_0, sel2[0], busy[0], eoc[0]};
        return {clear_mmm[1], ld_a[1], ld_r[1], lock1[1], lock2[1], sel1_1, sel2[1], busy[1], eoc[1]};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            cyc[i] = cyc[i] + 1;
            if (rstb) begin
                act[i] = 1'b0;
                mrd[i] = 0;
            end else if (abort) begin
                act[i] = 1'b0;
            end else if (ena) begin
                if (!act[i]) begin
                    if (start) begin
                        act[i] = 1'b1;
                        p[i] = 1;
                        me[i] = e;
                        rx[i] = calc_rx(e, int'(exp_len), i == 1);
                        eocp[i] = PH * (rx[i] + 2) + 1;
                        mrd[i] = 0;
                        cyc[i] = 1;
                        eoc_at[i] = -1;
                        nlk[i] = 0;
                        lk[i] = '0;
                    end
                end else if (p[i] == eocp[i]) begin
                    act[i] = 1'b0;
                end else begin
                    if ((p[i] - 1) % PH == PH - 1 && (p[i] - 1) / PH >= 1 && (p[i] - 1) / PH <= rx[i])
                        mrd[i] = mrd[i] + 1;
                    p[i] = p[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dut_out(i) !== model_out(i)) begin
                    bad++;
                    $display("FAIL outputs[%0d] cyc=%0d got=%b want=%b", i, cyc[i], dut_out(i), model_out(i));
                end
                total++;
                if (((i == 0) ? rd0 : rd1) !== CW'(mrd[i])) begin
                    bad++;
                    $display("FAIL rounds_done[%0d] cyc=%0d got=%0d want=%0d", i, cyc[i], (i == 0) ? rd0 : rd1, mrd[i]);
                end
                if (dut_out(i)[0] === 1'b1) eoc_at[i] = cyc[i];
                if (dut_out(i)[8] === 1'b1 && dut_out(i)[4:3] == 2'b01 && nlk[i] < EW) begin
                    lk[i][nlk[i]] = dut_out(i)[6];
                    nlk[i] = nlk[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic go(input logic [EW-1:0] ev, input int len);
        @(negedge clk);
        e = ev;
        exp_len = CW'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy != 2'b00 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 400, 1);
        @(negedge clk);
    endtask

    task automatic wait_remap();
        int n;
        n = 0;
        while (!(sel1_0 == 2'b10 && ld_a[0] == 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("remap_timeout", n < 200, 1);
    endtask

    initial begin
        logic [9:0] snap;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; p[i] = 0; rx[i] = 0; mrd[i] = 0; eocp[i] = 0;
            cyc[i] = 0; eoc_at[i] = -1; nlk[i] = 0; lk[i] = '0; me[i] = '0;
        end
        rstb = 1'b1; ena = 1'b0; start = 1'b0; abort = 1'b0; e = '0; exp_len = '0;
        repeat (3) @(negedge clk);
        check("reset_out0", int'(dut_out(0)), 0);
        check("reset_out1", int'(dut_out(1)), 0);
        check("reset_rd", int'(rd0), 0);
        chk_en = 1'b1;
        rstb = 1'b0;
        ena = 1'b1;
        @(negedge clk);

        go(8'hB5, 8); wait_idle();
        check("b5_eoc0", eoc_at[0], 101);
        check("b5_eoc1", eoc_at[1], 101);
        check("b5_rd0", int'(rd0), 8);
        check("b5_lock1", int'(lk[0]), 'hB5);
        check("b5_nrounds", nlk[0], 8);

        go(8'h05, 8); wait_idle();
        check("e05_eoc1", eoc_at[1], 51);
        check("e05_nrounds1", nlk[1], 3);
        check("e05_lock1", int'(lk[1]), 5);
        check("e05_rd1", int'(rd1), 3);
        check("e05_eoc0", eoc_at[0], 101);

        go(8'h00, 8); wait_idle();
        check("e00_eoc1", eoc_at[1], 31);
        check("e00_rd1", int'(rd1), 1);

        go(8'hFF, 3); wait_idle();
        check("len3_eoc0", eoc_at[0], 51);
        check("len3_eoc1", eoc_at[1], 51);
        go(8'hFF, 0); wait_idle();
        check("len0_eoc0", eoc_at[0], 101);
        go(8'hFF, 12); wait_idle();
        check("len12_eoc0", eoc_at[0], 101);

        go(8'hB5, 8);
        repeat (2) @(negedge clk);
        snap = dut_out(0);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_map", int'(dut_out(0)), int'(snap));
        end
        ena = 1'b1;
        wait_remap();
        snap = dut_out(0);
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_remap", int'(dut_out(0)), int'(snap));
        end
        ena = 1'b1;
        wait_idle();
        check("stall_eoc0", eoc_at[0], 109);
        check("stall_eoc1", eoc_at[1], 109);

        go(8'hB5, 8);
        repeat (34) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_rd0", int'(rd0), 2);
        repeat (3) @(negedge clk);
        check("abort_no_eoc", eoc_at[0], -1);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle", int'(busy), 0);
        go(8'hB5, 8); wait_idle();
        check("restart_eoc0", eoc_at[0], 101);

        go(8'h05, 8);
        repeat (20) @(negedge clk);
        e = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("busy_start_eoc0", eoc_at[0], 101);
        check("busy_start_eoc1", eoc_at[1], 51);

        go(8'hB5, 8);
        wait_remap();
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        check("rst_remap_out0", int'(dut_out(0)), 0);
        check("rst_remap_rd0", int'(rd0), 0);
        repeat (3) @(negedge clk);
        check("rst_remap_no_eoc", eoc_at[0], -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rsa_sequencer.md
RSA_SEQUENCER -- requirements
Module: rsa_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: modulus/operand width; each MMM pass lasts WIDTH cycles; legal range WIDTH>=2.
REQ-002 SHALL have parameter EXP_WIDTH, default 8: exponent register width and maximum round count; legal range EXP_WIDTH>=1.
REQ-003 SHALL have parameter EARLY_EXIT, default 0: 1 ends the exponent rounds as soon as no set exponent bits remain.
REQ-004 SHALL have port clk  in  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port rstb  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port ena  in  1  global advance enable; 0 freezes all registers.
REQ-007 SHALL have port start  in  1  start request; sampled in IDLE only.
REQ-008 SHALL have port abort  in  1  synchronous return to IDLE; wins over ena and start.
REQ-009 SHALL have port E  in  EXP_WIDTH  exponent; captured on start.
REQ-010 SHALL have port exp_len  in  $clog2(EXP_WIDTH+1)  requested round count; captured on start.
REQ-011 SHALL have ports clear_mmm, ld_a, ld_r, lock1, lock2, sel2  out  1 each: datapath controls.
REQ-012 SHALL have port sel1  out  2  operand-mux select.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port eoc  out  1  one-cycle end-of-computation pulse.
REQ-015 SHALL have port rounds_done  out  $clog2(EXP_WIDTH+1)  count of completed exponent rounds in the current or last operation.

Function
REQ-016 SHALL implement states IDLE, PRE_MAP, MAP, POST_MAP, PRE_MMM, MMM, POST_MMM, PRE_REMAP, REMAP, POST_REMAP, EOC; registers SHALL update only when ena=1, except on abort.
REQ-017 SHALL, in IDLE with start=1 and ena=1: load exp_q<=E; load R<=exp_len, with 0 or values >EXP_WIDTH replaced by EXP_WIDTH; clear the step counter and rounds_done; go to PRE_MAP.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL sequence PRE_MAP -> MAP -> POST_MAP -> PRE_MMM; MAP, MMM and REMAP each SHALL last exactly WIDTH cycles.
REQ-020 SHALL use a step counter that increments in MAP, MMM and REMAP, leaves the state when it equals WIDTH-1, and clears to 0 in POST_MAP, POST_MMM and POST_REMAP.
REQ-021 SHALL, in POST_MMM: shift exp_q right by 1 with zero fill; increment rounds_done; go to PRE_REMAP if rounds_done+1==R, or if EARLY_EXIT=1 and (exp_q>>1)==0; otherwise go to PRE_MMM.
REQ-022 SHALL perform at least one round, even for E=0.
REQ-023 SHALL sequence PRE_REMAP -> REMAP -> POST_REMAP -> EOC -> IDLE.
REQ-024 SHALL decode outputs as a pure function of state and exp_q[0], according to REQ-025 to REQ-030.
REQ-025 IDLE: all outputs 0, sel1=00.
REQ-026 PRE_MAP/MAP/POST_MAP: clear_mmm=1, lock1=1, lock2=1, sel1=00, sel2=0; ld_a=1 in PRE_MAP only; ld_r=1 in POST_MAP only.
REQ-027 PRE_MMM/MMM/POST_MMM: clear_mmm=1, lock1=exp_q[0] sampled before the shift, lock2=1, sel1=01, sel2=1; ld_a=1 in PRE_MMM only; ld_r=1 in POST_MMM only.
REQ-028 PRE_REMAP/REMAP/POST_REMAP: clear_mmm=1, lock1=1, lock2=0, sel1=10, sel2=1; ld_a=1 in PRE_REMAP only; ld_r=1 in POST_REMAP only.
REQ-029 EOC: same outputs as POST_REMAP, plus eoc=1.
REQ-030 busy SHALL be 0 in IDLE only.
REQ-031 With rounds executed Rx, eoc SHALL be high in cycle (WIDTH+2)*(Rx+2)+1 after the start-sampling edge (cycle 0), plus one cycle per ena=0 cycle; for WIDTH=8, Rx=8 this is cycle 101.
REQ-032 SHALL hold the state, counters, exp_q and therefore all outputs unchanged while ena=0.
REQ-033 SHALL, on abort=1 in any state: go to IDLE at the next edge; clear the counters and exp_q; not pulse eoc; rounds_done SHALL retain its value.
REQ-034 SHALL treat a simultaneous abort and start in IDLE as abort (remain in IDLE).
REQ-035 SHALL treat an unreachable state encoding as IDLE at the next edge.

Reset
REQ-036 SHALL, when rstb=1 at a rising edge regardless of ena: state=IDLE, exp_q=0, step counter=0, rounds_done=0, R=EXP_WIDTH; outputs SHALL equal the IDLE decode (all 0).
REQ-037 SHALL terminate an in-progress operation on reset mid-operation without an eoc pulse.

Verification (WIDTH=8, EXP_WIDTH=8)
REQ-038 SHALL cover: EARLY_EXIT=0, E=0xB5, exp_len=8 -> lock1 per round 1,0,1,0,1,1,0,1; eoc at cycle 101; rounds_done=8.
REQ-039 SHALL cover: EARLY_EXIT=1, E=0x05, exp_len=8 -> 3 rounds with lock1 1,0,1; eoc at cycle 51. Also E=0x00 -> 1 round; eoc at cycle 31.
REQ-040 SHALL cover: EARLY_EXIT=0, E=0xFF, exp_len=3 -> 3 rounds; eoc at cycle 51. Also exp_len=0 -> 8 rounds; eoc at cycle 101.
REQ-041 SHALL cover: ena=0 for 5 cycles during MAP, plus 3 cycles during REMAP -> eoc at cycle 109; outputs constant during the stalls.
REQ-042 SHALL cover: abort in MMM of round 3 -> busy=0 next cycle; no eoc; rounds_done=2. A new start then completes at the nominal cycle.
REQ-043 SHALL cover: start pulsed while busy -> no effect. rstb=1 in REMAP -> IDLE outputs next cycle; no eoc.
